// File: rtl/ram256_wb_ctrl.sv
// Wishbone classic slave front-end for a RAM256 macro. The RAM-side signals and the ack are registered.
// Each transfer takes four cycles: request, RAM access, response and ack.
module ram256_wb_ctrl #(
  parameter int WSIZE    = 4,
  parameter int AW       = 8,
  parameter int ADDR_LSB = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [WSIZE-1:0]     wb_sel_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [WSIZE*8-1:0]   wb_dat_i,
  output logic [WSIZE*8-1:0]   wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 ram_en0,
  output logic [WSIZE-1:0]     ram_we0,
  output logic [AW-1:0]        ram_a0,
  output logic [WSIZE*8-1:0]   ram_di0,
  input  logic [WSIZE*8-1:0]   ram_do0
);

  localparam int DW = WSIZE * 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP, ACK} state_t;

  state_t            state_q;
  logic              we_q;
  logic              ack_q;
  logic [DW-1:0]     rdat_q;
  logic              en_q;
  logic [WSIZE-1:0]  we0_q;
  logic [AW-1:0]     a0_q;
  logic [DW-1:0]     di_q;

  // Byte-offset bits and bits above the RAM's word index are ignored.
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:AW+ADDR_LSB], wb_adr_i[ADDR_LSB-1:0]};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      en_q    <= 1'b0;
      we0_q   <= '0;
      a0_q    <= '0;
      di_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            we_q    <= wb_we_i;
            en_q    <= 1'b1;
            a0_q    <= wb_adr_i[AW+ADDR_LSB-1:ADDR_LSB];
            di_q    <= wb_dat_i;
            we0_q   <= wb_we_i ? wb_sel_i : '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          // The RAM commits on this edge, so an aborted write still lands.
          en_q    <= 1'b0;
          we0_q   <= '0;
          state_q <= wb_cyc_i ? RESP : IDLE;
        end
        RESP: begin
          if (!wb_cyc_i) begin
            state_q <= IDLE;
          end else begin
            if (!we_q) rdat_q <= ram_do0;
            ack_q   <= 1'b1;
            state_q <= ACK;
          end
        end
        ACK: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_dat_o = rdat_q;
  assign wb_ack_o = ack_q;
  assign ram_en0  = en_q;
  assign ram_we0  = we0_q;
  assign ram_a0   = a0_q;
  assign ram_di0  = di_q;

endmodule

// File: tb/tb_ram256_wb_ctrl.sv
// Bench for ram256_wb_ctrl: behavioural RAM256 macro, reference memory and ack-driven scoreboard.
module tb_ram256_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, dat_i = '0;
  logic [31:0] dat_o;
  logic        ack;
  logic        ram_en0;
  logic [3:0]  ram_we0;
  logic [7:0]  ram_a0;
  logic [31:0] ram_di0;
  logic [31:0] ram_do0 = '0;

  logic [31:0] ram_mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] exp_q [$];
  logic [31:0] last_dat = '0;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  ram256_wb_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_we_i(we), .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_dat_o(dat_o), .wb_ack_o(ack),
    .ram_en0(ram_en0), .ram_we0(ram_we0), .ram_a0(ram_a0),
    .ram_di0(ram_di0), .ram_do0(ram_do0)
  );

  // Behavioural RAM256 macro: synchronous read, per-byte write enables.
  always @(posedge clk) begin
    if (ram_en0) begin
      ram_do0 <= ram_mem[ram_a0];
      for (int i = 0; i < 4; i++)
        if (ram_we0[i]) ram_mem[ram_a0][8*i +: 8] <= ram_di0[8*i +: 8];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every ack pops one expected wb_dat_o value.
  always @(negedge clk) begin
    if (!rst && ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack at %0t", $time);
      end else begin
        check("ack_rdata", dat_o, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic xfer(input logic w, input logic [31:0] a_byte, input logic [31:0] d,
                      input logic [3:0] s, input logic [7:0] exp_a0);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a_byte; dat_i = d; sel = s;
    if (w) ref_write(exp_a0, d, s);
    else   last_dat = ref_mem[exp_a0];
    exp_q.push_back(last_dat);
    tick();
    check("req_en0", {31'b0, ram_en0}, 32'd1);
    check("req_a0", {24'b0, ram_a0}, {24'b0, exp_a0});
    check("req_we0", {28'b0, ram_we0}, {28'b0, (w ? s : 4'b0)});
    if (w) check("req_di0", ram_di0, d);
    tick();
    check("en0_one_cycle", {31'b0, ram_en0}, 32'd0);
    check("we0_after_req", {28'b0, ram_we0}, 32'd0);
    tick();
    check("ack_latency", {31'b0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0;
    tick();
    check("ack_one_cycle", {31'b0, ack}, 32'd0);
  endtask

  initial begin
    logic [7:0]  ridx;
    logic [31:0] radr, rdat;
    logic [3:0]  rsel;
    logic        rw;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    #2;
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_en0", {31'b0, ram_en0}, 32'd0);
    check("rst_we0", {28'b0, ram_we0}, 32'd0);
    check("rst_a0", {24'b0, ram_a0}, 32'd0);
    check("rst_di0", ram_di0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    xfer(1'b1, 32'h004, 32'hDEADBEEF, 4'hF, 8'h01);
    xfer(1'b0, 32'h004, 32'h0, 4'hF, 8'h01);
    check("read_full", dat_o, 32'hDEADBEEF);
    xfer(1'b1, 32'h004, 32'h0000AA00, 4'h2, 8'h01);
    xfer(1'b0, 32'h004, 32'h0, 4'hF, 8'h01);
    check("read_partial", dat_o, 32'hDEADAAEF);
    xfer(1'b1, 32'h004, 32'h99999999, 4'h0, 8'h01);
    check("sel0_keeps_dat", dat_o, 32'hDEADAAEF);
    xfer(1'b0, 32'h004, 32'h0, 4'hF, 8'h01);
    check("sel0_mem_unchanged", dat_o, 32'hDEADAAEF);

    xfer(1'b1, 32'h1FC, 32'h11111111, 4'hF, 8'h7F);
    xfer(1'b1, 32'h200, 32'h22222222, 4'hF, 8'h80);
    xfer(1'b0, 32'h1FC, 32'h0, 4'hF, 8'h7F);
    check("bank_lo", dat_o, 32'h11111111);
    xfer(1'b0, 32'h600, 32'h0, 4'hF, 8'h80);
    check("bank_alias", dat_o, 32'h22222222);

    // Abort: cycle dropped during REQ, no ack and no data update.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h004; sel = 4'hF;
    tick();
    check("abort_en0", {31'b0, ram_en0}, 32'd1);
    cyc = 1'b0; stb = 1'b0;
    tick(); tick();
    check("abort_no_ack", {31'b0, ack}, 32'd0);
    tick();
    check("abort_no_ack2", {31'b0, ack}, 32'd0);
    check("abort_dat_held", dat_o, 32'h22222222);
    xfer(1'b0, 32'h004, 32'h0, 4'hF, 8'h01);
    check("after_abort", dat_o, 32'hDEADAAEF);

    // Reset while the write request is on the RAM pins.
    xfer(1'b1, 32'h010, 32'h12345678, 4'hF, 8'h04);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h010; dat_i = 32'h55AA55AA; sel = 4'hF;
    tick();
    check("rstop_en0_before", {31'b0, ram_en0}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstop_en0_drop", {31'b0, ram_en0}, 32'd0);
    check("rstop_we0_drop", {28'b0, ram_we0}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    last_dat = '0;
    tick();
    rst = 1'b0;
    tick();
    xfer(1'b0, 32'h010, 32'h0, 4'hF, 8'h04);
    check("rstop_mem_prior", dat_o, 32'h12345678);

    // Back-to-back mixed traffic over a small window so reads hit written words.
    for (int n = 0; n < 16; n++) begin
      ridx = 8'($urandom_range(0, 7)) + 8'h40;
      radr = {22'($urandom), ridx, 2'($urandom)};
      rdat = $urandom;
      rsel = 4'($urandom);
      rw   = (n < 4) ? 1'b1 : 1'($urandom);
      xfer(rw, radr, rdat, rsel, ridx);
    end

    tick(); tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
